// File: rtl/bp_me_trace_pkg.sv
// rtl/bp_me_trace_pkg.sv - shared opcode/state types and ROM entry struct macro for trace replay
`define BP_ME_TRACE_ENTRY_S(width_mp) typedef struct packed { bp_me_trace_pkg::bp_me_trace_op_e opcode; logic [width_mp-1:0] payload; } bp_me_trace_entry_s

package bp_me_trace_pkg;

    // Width of the WAIT cycle count carried in payload[31:0]
    localparam int wait_width_gp = 32;

    typedef enum logic [3:0] {
        e_op_nop        = 4'd0,
        e_op_send       = 4'd1,
        e_op_recv       = 4'd2,
        e_op_done       = 4'd3,
        e_op_wait       = 4'd4,
        e_op_finish_all = 4'd5
    } bp_me_trace_op_e;

    typedef enum logic [2:0] {
        e_reset,
        e_exec,
        e_wait,
        e_done,
        e_error
    } bp_me_trace_state_e;

endpackage

// File: rtl/bp_me_trace_replay_mc_if.sv
// rtl/bp_me_trace_replay_mc_if.sv - per-channel packet/response link between replay master and DUT
interface bp_me_trace_replay_mc_if #(
    parameter int num_channels_p = 2,
    parameter int ring_width_p   = 128
);
    // Names are from the master's point of view
    logic [num_channels_p-1:0]              v_o;
    logic [num_channels_p*ring_width_p-1:0] data_o;
    logic [num_channels_p-1:0]              yumi_i;
    logic [num_channels_p-1:0]              v_i;
    logic [num_channels_p*ring_width_p-1:0] data_i;
    logic [num_channels_p-1:0]              ready_o;

    modport master (output v_o, data_o, ready_o, input yumi_i, v_i, data_i);
    modport slave  (input v_o, data_o, ready_o, output yumi_i, v_i, data_i);
endinterface

// File: rtl/bp_me_trace_replay_chan.sv
// rtl/bp_me_trace_replay_chan.sv - single trace channel: PC, WAIT counter, watchdog and FSM
module bp_me_trace_replay_chan
    import bp_me_trace_pkg::*;
#(
    parameter int ring_width_p     = 128,
    parameter int rom_addr_width_p = 20,
    parameter int timeout_p        = 100000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [4+ring_width_p-1:0]   rom_data_i,
    output logic                        v_o,
    output logic [ring_width_p-1:0]     data_o,
    input  logic                        yumi_i,
    input  logic                        v_i,
    input  logic [ring_width_p-1:0]     data_i,
    output logic                        ready_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic                        timeout_o
);
    `BP_ME_TRACE_ENTRY_S(ring_width_p);

    localparam int wd_width_lp = $clog2(timeout_p + 1);

    bp_me_trace_entry_s          entry;
    bp_me_trace_state_e          state_q;
    logic [rom_addr_width_p-1:0] pc_q;
    logic [wait_width_gp-1:0]    wait_cnt_q;
    logic [wd_width_lp-1:0]      wd_q;
    logic                        timeout_q;
    logic [wait_width_gp-1:0]    wait_len;
    logic                        active;
    logic                        retire, fault, wait_start, halt;

    assign entry    = rom_data_i;
    assign wait_len = entry.payload[wait_width_gp-1:0];

    // Handshakes only exist in EXEC while enabled; reset kills them in the same cycle
    assign active  = en_i & ~reset_i & (state_q == e_exec);
    assign v_o     = active & (entry.opcode == e_op_send);
    assign ready_o = active & (entry.opcode == e_op_recv);
    assign data_o  = v_o ? entry.payload : '0;

    assign rom_addr_o = pc_q;
    assign done_o     = (state_q == e_done);
    assign error_o    = (state_q == e_error);
    assign timeout_o  = timeout_q;

    // Decode what the current entry does this cycle
    always_comb begin
        retire     = 1'b0;
        fault      = 1'b0;
        wait_start = 1'b0;
        halt       = 1'b0;
        if (state_q == e_exec) begin
            case (entry.opcode)
                e_op_nop:  retire = 1'b1;
                e_op_send: retire = yumi_i;
                e_op_recv: begin
                    retire = v_i & (data_i == entry.payload);
                    fault  = v_i & (data_i != entry.payload);
                end
                e_op_wait: begin
                    retire     = (wait_len == '0);
                    wait_start = (wait_len != '0);
                end
                e_op_done, e_op_finish_all: halt = 1'b1;
                default: fault = 1'b1;
            endcase
        end else if (state_q == e_wait) begin
            retire = (wait_cnt_q == wait_width_gp'(1));
        end
    end

    // Channel FSM; retire is checked before the watchdog so it wins a tie
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_reset;
            pc_q       <= '0;
            wait_cnt_q <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
        end else if (en_i) begin
            case (state_q)
                e_reset: state_q <= e_exec;
                e_exec, e_wait: begin
                    if (retire) begin
                        wd_q <= '0;
                        if (&pc_q) begin
                            state_q <= e_error;
                        end else begin
                            pc_q    <= pc_q + rom_addr_width_p'(1);
                            state_q <= e_exec;
                        end
                    end else if (fault) begin
                        state_q <= e_error;
                    end else if (wait_start) begin
                        state_q    <= e_wait;
                        wait_cnt_q <= wait_len;
                        wd_q       <= '0;
                    end else if (state_q == e_wait) begin
                        wait_cnt_q <= wait_cnt_q - wait_width_gp'(1);
                        wd_q       <= '0;
                    end else if (halt) begin
                        state_q <= e_done;
                    end else if (wd_q == wd_width_lp'(timeout_p - 1)) begin
                        state_q   <= e_error;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + wd_width_lp'(1);
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

endmodule

// File: rtl/bp_me_trace_replay_mc.sv
// rtl/bp_me_trace_replay_mc.sv - multi-channel trace replay master with done/error summary and cycle counter
module bp_me_trace_replay_mc
    import bp_me_trace_pkg::*;
#(
    parameter int num_channels_p    = 2,
    parameter int ring_width_p      = 128,
    parameter int rom_addr_width_p  = 20,
    parameter int timeout_p         = 100000,
    parameter int cycle_cnt_width_p = 32,
    localparam int chan_id_width_lp = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   en_i,
    output logic [num_channels_p*rom_addr_width_p-1:0] rom_addr_o,
    input  logic [num_channels_p*(4+ring_width_p)-1:0] rom_data_i,
    bp_me_trace_replay_mc_if.master                link_if,
    output logic [num_channels_p-1:0]              chan_done_o,
    output logic                                   done_o,
    output logic                                   error_o,
    output logic [chan_id_width_lp-1:0]            error_chan_o,
    output logic [num_channels_p-1:0]              timeout_o,
    output logic [cycle_cnt_width_p-1:0]           cycle_cnt_o
);
    logic [num_channels_p-1:0]    chan_err;
    logic [chan_id_width_lp-1:0]  err_idx;
    logic                         done_q, error_q;
    logic [chan_id_width_lp-1:0]  error_chan_q;
    logic [cycle_cnt_width_p-1:0] cycle_cnt_q;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
        bp_me_trace_replay_chan #(
            .ring_width_p     (ring_width_p),
            .rom_addr_width_p (rom_addr_width_p),
            .timeout_p        (timeout_p)
        ) u_chan (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .en_i       (en_i),
            .rom_addr_o (rom_addr_o[c*rom_addr_width_p +: rom_addr_width_p]),
            .rom_data_i (rom_data_i[c*(4+ring_width_p) +: (4+ring_width_p)]),
            .v_o        (link_if.v_o[c]),
            .data_o     (link_if.data_o[c*ring_width_p +: ring_width_p]),
            .yumi_i     (link_if.yumi_i[c]),
            .v_i        (link_if.v_i[c]),
            .data_i     (link_if.data_i[c*ring_width_p +: ring_width_p]),
            .ready_o    (link_if.ready_o[c]),
            .done_o     (chan_done_o[c]),
            .error_o    (chan_err[c]),
            .timeout_o  (timeout_o[c])
        );
    end

    // Lowest-index channel in error; 0 when nothing has failed
    always_comb begin
        err_idx = '0;
        for (int c = num_channels_p - 1; c >= 0; c--) begin
            if (chan_err[c]) err_idx = chan_id_width_lp'(c);
        end
    end

    // Registered summary so the bench sees a clean, glitch-free finish condition
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            error_chan_q <= '0;
        end else begin
            done_q       <= (&chan_done_o) & ~(|chan_err);
            error_q      <= |chan_err;
            error_chan_q <= err_idx;
        end
    end

    // Free-running saturating cycle counter, independent of en_i
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_cnt_q <= '0;
        end else if (~&cycle_cnt_q) begin
            cycle_cnt_q <= cycle_cnt_q + cycle_cnt_width_p'(1);
        end
    end

    assign done_o       = done_q;
    assign error_o      = error_q;
    assign error_chan_o = error_chan_q;
    assign cycle_cnt_o  = cycle_cnt_q;

endmodule

// File: tb/tb_bp_me_trace_replay_mc.sv
// tb/tb_bp_me_trace_replay_mc.sv - self-checking bench for bp_me_trace_replay_mc
module tb_bp_me_trace_replay_mc;
    localparam int NC = 2;
    localparam int RW = 32;
    localparam int AW = 4;
    localparam int TO = 20;
    localparam int CW = 8;
    localparam int EW = 4 + RW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b1;
    logic [NC*AW-1:0] rom_addr;
    logic [NC*EW-1:0] rom_data;
    logic [NC-1:0] chan_done;
    logic          done;
    logic          error;
    logic [0:0]    error_chan;
    logic [NC-1:0] timeout;
    logic [CW-1:0] cycle_cnt;

    bp_me_trace_replay_mc_if #(.num_channels_p(NC), .ring_width_p(RW)) ifc ();

    bp_me_trace_replay_mc #(
        .num_channels_p(NC), .ring_width_p(RW), .rom_addr_width_p(AW),
        .timeout_p(TO), .cycle_cnt_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .link_if(ifc),
        .chan_done_o(chan_done), .done_o(done), .error_o(error),
        .error_chan_o(error_chan), .timeout_o(timeout), .cycle_cnt_o(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Trace ROMs, combinational on the DUT's address
    logic [3:0]  rom_op [NC][16];
    logic [31:0] rom_pl [NC][16];
    for (genvar c = 0; c < NC; c++) begin : g_rom
        assign rom_data[c*EW +: EW] = {rom_op[c][rom_addr[c*AW +: AW]], rom_pl[c][rom_addr[c*AW +: AW]]};
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // DUT-side behaviour: 0 loopback, 1 fixed response, 2 silent
    int          mode [NC];
    bit          hold_yumi [NC];
    bit          rnd = 1'b0;
    logic [31:0] fixed_resp [NC];
    logic [31:0] lq [NC][$];
    logic [31:0] sent_log [NC][$];
    logic [31:0] exp_q [NC][$];
    int          ystall [NC];
    int          vstall [NC];
    bit          prev_v [NC];
    bit          prev_y [NC];
    logic [31:0] prev_d [NC];

    // Decide handshakes half a cycle ahead of the edge that consumes them
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            bit          y, vi;
            logic [31:0] d, pkt;
            pkt = ifc.data_o[c*RW +: RW];
            if (prev_v[c] && !prev_y[c] && ifc.v_o[c])
                check("data_o_stable", pkt, prev_d[c]);
            y = ifc.v_o[c] && !hold_yumi[c] && (!rnd || ystall[c] >= 3 || $urandom_range(0, 1) == 1);
            ystall[c] = (ifc.v_o[c] && !y) ? ystall[c] + 1 : 0;
            ifc.yumi_i[c] = y;
            if (y) begin
                sent_log[c].push_back(pkt);
                if (mode[c] == 0) lq[c].push_back(pkt);
            end
            vi = 1'b0;
            d  = '0;
            if (mode[c] == 1) begin
                vi = 1'b1;
                d  = fixed_resp[c];
            end else if (mode[c] == 0 && lq[c].size() > 0 &&
                         (!rnd || vstall[c] >= 3 || $urandom_range(0, 1) == 1)) begin
                vi = 1'b1;
                d  = lq[c][0];
            end
            vstall[c] = (ifc.ready_o[c] && !vi) ? vstall[c] + 1 : 0;
            ifc.v_i[c] = vi;
            ifc.data_i[c*RW +: RW] = d;
            if (vi && ifc.ready_o[c] && mode[c] == 0) void'(lq[c].pop_front());
            prev_v[c] = ifc.v_o[c];
            prev_y[c] = y;
            prev_d[c] = pkt;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        reset = 1'b1;
        en    = 1'b1;
        tick(1);
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 16; i++) begin
                rom_op[c][i] = 4'd3;
                rom_pl[c][i] = '0;
            end
            lq[c].delete();
            sent_log[c].delete();
            exp_q[c].delete();
            mode[c] = 0;
            hold_yumi[c] = 1'b0;
            fixed_resp[c] = '0;
        end
        rnd = 1'b0;
    endtask

    // After this returns the bench is in cycle 0 (state RESET)
    task automatic release_reset();
        tick(1);
        reset = 1'b0;
    endtask

    // Random program: NOPs, short WAITs and SEND/RECV pairs, occasionally with a wrong RECV value
    task automatic gen_prog(input int c, output logic err, output logic [3:0] pc);
        int          pos;
        int          k;
        logic [31:0] x;
        bit          bad;
        pos = 0;
        err = 1'b0;
        pc  = '0;
        while (pos < 13) begin
            k = $urandom_range(0, 2);
            if (k == 0) begin
                rom_op[c][pos] = 4'd0;
                rom_pl[c][pos] = $urandom;
                pos++;
            end else if (k == 1) begin
                rom_op[c][pos] = 4'd4;
                rom_pl[c][pos] = $urandom_range(0, 4);
                pos++;
            end else begin
                x   = $urandom;
                bad = ($urandom_range(0, 7) == 0);
                rom_op[c][pos]   = 4'd1;
                rom_pl[c][pos]   = x;
                rom_op[c][pos+1] = 4'd2;
                rom_pl[c][pos+1] = bad ? (x ^ 32'h100) : x;
                if (!err) begin
                    exp_q[c].push_back(x);
                    if (bad) begin
                        err = 1'b1;
                        pc  = 4'(pos + 1);
                    end
                end
                pos += 2;
            end
        end
        rom_op[c][pos] = 4'd3;
        if (!err) pc = 4'(pos);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pl;
        logic [31:0] resp;
        logic        exp_done;
        logic        exp_err;
        logic [3:0]  exp_pc;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic        e0, e1;
        logic [3:0]  p0, p1;
        logic [1:0]  exp_cd;

        vecs[0] = '{4'd0, 32'h0,  32'h0,  1'b1, 1'b0, 4'd1};
        vecs[1] = '{4'd1, 32'h12, 32'h0,  1'b1, 1'b0, 4'd1};
        vecs[2] = '{4'd2, 32'h34, 32'h34, 1'b1, 1'b0, 4'd1};
        vecs[3] = '{4'd2, 32'h34, 32'h35, 1'b0, 1'b1, 4'd0};
        vecs[4] = '{4'd4, 32'h3,  32'h0,  1'b1, 1'b0, 4'd1};
        vecs[5] = '{4'd4, 32'h0,  32'h0,  1'b1, 1'b0, 4'd1};
        vecs[6] = '{4'd5, 32'h0,  32'h0,  1'b1, 1'b0, 4'd0};
        vecs[7] = '{4'd3, 32'h0,  32'h0,  1'b1, 1'b0, 4'd0};
        vecs[8] = '{4'd6, 32'h0,  32'h0,  1'b0, 1'b1, 4'd0};
        vecs[9] = '{4'd15, 32'h0, 32'h0,  1'b0, 1'b1, 4'd0};

        for (int c = 0; c < NC; c++) begin
            mode[c] = 0; hold_yumi[c] = 1'b0; fixed_resp[c] = '0;
            ystall[c] = 0; vstall[c] = 0; prev_v[c] = 1'b0; prev_y[c] = 1'b0; prev_d[c] = '0;
        end

        // Reset state
        begin_test();
        tick(1);
        check("reset_v_o", ifc.v_o, 2'b00);
        check("reset_ready_o", ifc.ready_o, 2'b00);
        check("reset_done", {chan_done, done, error, timeout}, 6'b0);
        check("reset_cycle_cnt", cycle_cnt, 8'd0);
        check("reset_rom_addr", rom_addr, 8'd0);

        // Single-instruction table
        for (int i = 0; i < 10; i++) begin
            begin_test();
            rom_op[0][0] = vecs[i].op;
            rom_pl[0][0] = vecs[i].pl;
            mode[0] = 1;
            fixed_resp[0] = vecs[i].resp;
            release_reset();
            tick(12);
            check($sformatf("vec%0d_chan_done", i), chan_done[0], vecs[i].exp_done);
            check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            check($sformatf("vec%0d_error", i), error, vecs[i].exp_err);
            check($sformatf("vec%0d_pc", i), rom_addr[3:0], vecs[i].exp_pc);
        end

        // SEND/RECV/DONE with yumi held off for three cycles
        begin_test();
        rom_op[0][0] = 4'd1; rom_pl[0][0] = 32'hA5;
        rom_op[0][1] = 4'd2; rom_pl[0][1] = 32'hA5;
        hold_yumi[0] = 1'b1;
        release_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check("t1_v_o_held", ifc.v_o[0], 1'b1);
            check("t1_data_held", ifc.data_o[31:0], 32'hA5);
        end
        hold_yumi[0] = 1'b0;
        tick(2);
        check("t1_cd_c5", chan_done, 2'b10);
        tick(1);
        check("t1_cd_c6", chan_done, 2'b11);
        check("t1_done_c6", done, 1'b0);
        tick(1);
        check("t1_done_c7", done, 1'b1);
        check("t1_error", error, 1'b0);
        check("t1_sent_n", sent_log[0].size(), 1);

        // RECV mismatch at index 2
        begin_test();
        rom_op[0][0] = 4'd0; rom_op[0][1] = 4'd0;
        rom_op[0][2] = 4'd2; rom_pl[0][2] = 32'h10;
        mode[0] = 1; fixed_resp[0] = 32'h11;
        release_reset();
        tick(8);
        check("t2_error", error, 1'b1);
        check("t2_error_chan", error_chan, 1'b0);
        check("t2_pc_frozen", rom_addr[3:0], 4'd2);
        check("t2_timeout", timeout, 2'b00);
        check("t2_ready_off", ifc.ready_o[0], 1'b0);

        // Error priority: only ch1 fails, then both fail
        begin_test();
        rom_op[1][0] = 4'd7;
        release_reset();
        tick(5);
        check("t2b_error_chan1", error_chan, 1'b1);
        check("t2b_cd", chan_done, 2'b01);
        check("t2b_done", done, 1'b0);
        begin_test();
        rom_op[0][0] = 4'd9;
        rom_op[1][0] = 4'd7;
        release_reset();
        tick(5);
        check("t2c_error_chan0", error_chan, 1'b0);
        check("t2c_error", error, 1'b1);

        // ch1 WAIT 0, WAIT 5, DONE against a 4-packet loopback on ch0
        begin_test();
        for (int k = 0; k < 4; k++) begin
            rom_op[0][2*k]   = 4'd1; rom_pl[0][2*k]   = 32'hC0DE0000 + k;
            rom_op[0][2*k+1] = 4'd2; rom_pl[0][2*k+1] = 32'hC0DE0000 + k;
        end
        rom_op[1][0] = 4'd4; rom_pl[1][0] = 32'd0;
        rom_op[1][1] = 4'd4; rom_pl[1][1] = 32'd5;
        release_reset();
        tick(8);
        check("t3_cd_c8", chan_done, 2'b00);
        tick(1);
        check("t3_cd_c9", chan_done, 2'b10);
        tick(1);
        check("t3_cd_c10", chan_done, 2'b11);
        check("t3_done_c10", done, 1'b0);
        tick(1);
        check("t3_done_c11", done, 1'b1);
        check("t3_sent_n", sent_log[0].size(), 4);

        // Watchdog on a silent RECV; ch1 WAITs longer than the timeout
        begin_test();
        rom_op[0][0] = 4'd2; rom_pl[0][0] = 32'h5;
        mode[0] = 2;
        rom_op[1][0] = 4'd4; rom_pl[1][0] = 32'd25;
        release_reset();
        tick(20);
        check("t4_timeout_c20", timeout, 2'b00);
        check("t4_error_c20", error, 1'b0);
        tick(1);
        check("t4_timeout_c21", timeout, 2'b01);
        tick(1);
        check("t4_error_c22", error, 1'b1);
        tick(5);
        check("t4_cd_c27", chan_done, 2'b00);
        tick(1);
        check("t4_cd_c28", chan_done, 2'b10);
        check("t4_timeout_c28", timeout, 2'b01);
        check("t4_error_chan", error_chan, 1'b0);

        // en_i dropped for 10 cycles in the middle of a stalled SEND
        begin_test();
        rom_op[0][0] = 4'd1; rom_pl[0][0] = 32'h77;
        hold_yumi[0] = 1'b1;
        release_reset();
        tick(5);
        check("t5_v_o_before", ifc.v_o[0], 1'b1);
        check("t5_cnt_before", cycle_cnt, 8'd5);
        en = 1'b0;
        #1;
        check("t5_v_o_en_low", ifc.v_o[0], 1'b0);
        tick(10);
        check("t5_cnt_after", cycle_cnt, 8'd15);
        check("t5_pc_frozen", rom_addr[3:0], 4'd0);
        en = 1'b1;
        #1;
        check("t5_v_o_resume", ifc.v_o[0], 1'b1);
        check("t5_data_resume", ifc.data_o[31:0], 32'h77);
        tick(10);
        check("t5_no_timeout", timeout, 2'b00);
        check("t5_v_o_c25", ifc.v_o[0], 1'b1);
        hold_yumi[0] = 1'b0;
        tick(2);
        check("t5_cd", chan_done[0], 1'b1);
        check("t5_sent_n", sent_log[0].size(), 1);
        if (sent_log[0].size() > 0) check("t5_sent_data", sent_log[0][0], 32'h77);

        // Illegal opcode 0xF at PC 3
        begin_test();
        rom_op[0][0] = 4'd0; rom_op[0][1] = 4'd0; rom_op[0][2] = 4'd0;
        rom_op[0][3] = 4'hF;
        release_reset();
        tick(6);
        check("t6_error", error, 1'b1);
        check("t6_pc", rom_addr[3:0], 4'd3);

        // PC at the top of the address space must not wrap
        begin_test();
        for (int i = 0; i < 16; i++) rom_op[0][i] = 4'd0;
        release_reset();
        tick(20);
        check("t7_wrap_error", error, 1'b1);
        check("t7_wrap_pc", rom_addr[3:0], 4'd15);
        check("t7_wrap_timeout", timeout, 2'b00);

        // Reset asserted during a stalled SEND
        begin_test();
        rom_op[0][0] = 4'd1; rom_pl[0][0] = 32'h3C;
        hold_yumi[0] = 1'b1;
        release_reset();
        tick(3);
        check("t8_v_o_pre", ifc.v_o[0], 1'b1);
        reset = 1'b1;
        #1;
        check("t8_v_o_same_cycle", ifc.v_o[0], 1'b0);
        tick(1);
        check("t8_v_o_next", ifc.v_o[0], 1'b0);
        check("t8_pc", rom_addr, 8'd0);
        check("t8_cnt", cycle_cnt, 8'd0);
        reset = 1'b0;
        tick(1);
        check("t8_v_o_again", ifc.v_o[0], 1'b1);

        // Cycle counter saturation
        begin_test();
        release_reset();
        tick(254);
        check("t9_cnt_254", cycle_cnt, 8'd254);
        tick(1);
        check("t9_cnt_255", cycle_cnt, 8'd255);
        tick(3);
        check("t9_cnt_sat", cycle_cnt, 8'd255);

        // Random programs against the loopback DUT with random back-pressure
        for (int it = 0; it < 20; it++) begin
            begin_test();
            gen_prog(0, e0, p0);
            gen_prog(1, e1, p1);
            rnd = 1'b1;
            release_reset();
            tick(150);
            exp_cd = {~e1, ~e0};
            check($sformatf("rnd%0d_cd", it), chan_done, exp_cd);
            check($sformatf("rnd%0d_pc0", it), rom_addr[3:0], p0);
            check($sformatf("rnd%0d_pc1", it), rom_addr[7:4], p1);
            check($sformatf("rnd%0d_error", it), error, e0 | e1);
            check($sformatf("rnd%0d_error_chan", it), error_chan, (!e0 && e1) ? 1'b1 : 1'b0);
            check($sformatf("rnd%0d_done", it), done, !e0 && !e1);
            check($sformatf("rnd%0d_timeout", it), timeout, 2'b00);
            for (int c = 0; c < NC; c++) begin
                check($sformatf("rnd%0d_ch%0d_nsent", it, c), sent_log[c].size(), exp_q[c].size());
                for (int i = 0; i < exp_q[c].size() && i < sent_log[c].size(); i++)
                    check($sformatf("rnd%0d_ch%0d_pkt%0d", it, c, i), sent_log[c][i], exp_q[c][i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_me_trace_replay_mc.md
Name: bp_me_trace_replay_mc

Overview:
- Multi-channel trace replay master for BlackParrot memory-system testbenches; generalised successor to the single-channel trace node master plus fixed bench clock-count timeout.
- Each of num_channels_p independent channels fetches trace ROM entries, sends packets to a device under test (DUT), checks responses against expected values, and executes timed waits.
- Per-channel progress watchdog; aggregated done/error summary for the bench to finish on.

Parameters:
num_channels_p, 2, number of independent trace channels (1..16)
ring_width_p, 128, trace packet payload width
rom_addr_width_p, 20, trace ROM address width per channel
timeout_p, 100000, cycles without instruction retire before a channel is declared hung
cycle_cnt_width_p, 32, width of the global saturating cycle counter

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
en_i  in  1  global run enable; when low, all channels hold state and watchdogs do not count
rom_addr_o  out  num_channels_p*rom_addr_width_p  per-channel ROM address
rom_data_i  in  num_channels_p*(4+ring_width_p)  per-channel ROM entry, combinational w.r.t. rom_addr_o; [top 4] opcode, [rest] payload
v_o  out  num_channels_p  packet valid to DUT
data_o  out  num_channels_p*ring_width_p  packet to DUT
yumi_i  in  num_channels_p  DUT accepts packet (valid-yumi)
v_i  in  num_channels_p  response valid from DUT
data_i  in  num_channels_p*ring_width_p  response from DUT
ready_o  out  num_channels_p  master can accept response (valid-ready)
chan_done_o  out  num_channels_p  channel reached DONE
done_o  out  1  all channels done, none in error
error_o  out  1  any channel in ERROR
error_chan_o  out  max(1,clog2(num_channels_p))  lowest-index channel in error
timeout_o  out  num_channels_p  channel entered ERROR via watchdog
cycle_cnt_o  out  cycle_cnt_width_p  saturating cycles since reset

Behaviour:
- Opcodes: 0 NOP, 1 SEND, 2 RECV, 3 DONE, 4 WAIT (payload[31:0]=cycles), 5 FINISH_ALL (treated as DONE for this channel); any other value is illegal and drives the channel to ERROR.
- Per-channel FSM: RESET -> EXEC -> {WAIT, DONE, ERROR}. PC register counts ROM entries; the register is rom_addr_o.
- Reset: PC=0, state RESET (one cycle) then EXEC; all outputs 0; watchdog and cycle_cnt_o cleared. Reset mid-operation abandons in-flight packets; v_o drops the same cycle.
- EXEC/NOP: PC+1 next cycle.
- EXEC/SEND: v_o=1, data_o=payload; on yumi_i, PC+1 next cycle. v_o and data_o are stable until yumi_i. Zero-bubble: the next SEND can assert v_o the following cycle.
- EXEC/RECV: ready_o=1; on v_i, compare data_i with payload. Match: PC+1. Mismatch: ERROR, with PC held at the failing entry for debug.
- EXEC/WAIT: load counter with payload; enter WAIT; decrement each en_i cycle; at 0, PC+1 and return to EXEC. A count of 0 behaves as NOP (1 cycle).
- DONE/ERROR: absorbing until reset; v_o=0, ready_o=0.
- ready_o is 0 in every state except RECV.
- Watchdog, per channel:
  - increments each en_i cycle in EXEC/WAIT without PC advance; clears on PC advance;
  - a WAIT in progress counts as progress, so the watchdog is held at 0;
  - at timeout_p: state -> ERROR and timeout_o bit set.
  - Simultaneous retire and timeout: retire wins.
- PC wrap at 2^rom_addr_width_p-1: ERROR (no silent wrap).
- done_o = &chan_done_o & ~error_o, registered (1-cycle latency after last channel reaches DONE).
- error_o and error_chan_o are registered; error_chan_o is a priority-encoded lowest index and is 0 when no error.
- cycle_cnt_o increments every cycle after reset regardless of en_i and saturates at all-ones.
- en_i=0: FSMs frozen, v_o/ready_o forced 0, no handshakes occur.

Decomposition:
- Shared package bp_me_trace_pkg: bp_me_trace_op_e (4-bit opcode enum), bp_me_trace_state_e, and a macro declaring the ROM entry struct {opcode, payload} from ring_width_p.
- One sub-module, bp_me_trace_replay_chan: single-channel FSM with PC, WAIT counter and watchdog. The top module generate-instantiates it num_channels_p times and adds the aggregation logic and cycle counter.

Test Plan:
- 1 channel, ROM {SEND 0xA5, RECV 0xA5, DONE}; DUT loopback; yumi held low 3 cycles -> data_o stable those 3 cycles, chan_done_o[0]=1 and done_o=1 one cycle later, error_o=0.
- RECV expects 0x10 but DUT returns 0x11 -> error_o=1, error_chan_o=0, rom_addr_o frozen at the RECV index, timeout_o=0.
- 2 channels; ch1 is {WAIT 0, WAIT 5, DONE}; ch0 is a 4-packet loopback -> ch1 done at cycle 2+6+1 after reset release, done_o only after ch0 also done.
- timeout_p=20, ch0 RECV with DUT silent -> ERROR at exactly 20 en_i cycles, timeout_o=01, ch1 unaffected.
- en_i dropped for 10 cycles mid-SEND -> v_o=0, watchdog unchanged, cycle_cnt_o still +10; resumes identically.
- Illegal opcode 0xF at PC 3 -> ERROR; reset asserted mid-SEND -> v_o=0 next cycle, PC=0, cycle_cnt_o=0.
